// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES definitions used by the cipher core and the
//                round controller: round count, pipeline stages per round,
//                controller state encoding and round-counter width.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

  // AES-128 round count and register stages per full round in the core loop
  localparam int NR     = 10;
  localparam int STAGES = 4;

  // Round counter / rndNo width (holds 0..NR)
  localparam int RND_W  = 4;

  // Controller state encoding
  typedef logic [1:0] state_t;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/aes_round_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_ctrl_if
//  Description : Handshake and core-control bundle between the AES round
//                controller, the block source and the cipher core.
//  Ports       : in_valid  source offers plaintext/key pair
//                in_ready  controller can accept a block
//                accept    core load strobe (in_valid & in_ready)
//                rndNo     current round number to the core
//                enbKS     round-key register update enable
//                out_valid one-cycle cipher_text valid pulse
//                busy      block in flight
//  Modports    : master = controller side, slave = source/core side
//  Revision    : 1.0  initial release
// ============================================================================
interface aes_round_ctrl_if;
  import aes_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             accept;
  logic [RND_W-1:0] rndNo;
  logic             enbKS;
  logic             out_valid;
  logic             busy;

  modport master (
    input  in_valid,
    output in_ready,
    output accept,
    output rndNo,
    output enbKS,
    output out_valid,
    output busy
  );

  modport slave (
    output in_valid,
    input  in_ready,
    input  accept,
    input  rndNo,
    input  enbKS,
    input  out_valid,
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_ctrl
//  Description : Round sequencer for an iterative, STAGES-deep AES core.
//                IDLE -> RUN (NR rounds, last round one stage shorter since
//                MixColumns is bypassed) -> DONE (one-cycle out_valid) -> IDLE.
//  Ports       : clk   clock, rising edge
//                rstn  synchronous active-low reset
//                bus   aes_round_ctrl_if.master (handshake + core controls)
//  Parameters  : NR     number of AES rounds
//                STAGES register stages per full round
//  Revision    : 1.0  initial release
// ============================================================================
module aes_round_ctrl #(
  parameter int NR     = aes_pkg::NR,
  parameter int STAGES = aes_pkg::STAGES
) (
  input  wire               clk,
  input  wire               rstn,
  aes_round_ctrl_if.master  bus
);
  import aes_pkg::*;

  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic [RND_W-1:0] R_LAST      = RND_W'(NR);
  localparam logic [SW-1:0]    S_LAST      = SW'(STAGES - 1);
  // Final round skips the MixColumns stage, so it ends one stage early
  localparam logic [SW-1:0]    S_LAST_FINAL = SW'(STAGES - 2);

  state_t           state;
  logic [RND_W-1:0] r;
  logic [SW-1:0]    s;

  logic last_round;
  logic stage_end;
  logic idle_ready;
  logic take;

  assign last_round = (r == R_LAST);
  assign stage_end  = last_round ? (s == S_LAST_FINAL) : (s == S_LAST);

  // Every output is held inactive while rstn is low, whatever the state
  assign idle_ready = rstn && (state == IDLE);
  assign take       = idle_ready && bus.in_valid;

  assign bus.in_ready  = idle_ready;
  assign bus.accept    = take;
  assign bus.rndNo     = (rstn && state == RUN) ? r : '0;
  assign bus.enbKS     = rstn && (state == RUN) && stage_end;
  assign bus.out_valid = rstn && (state == DONE);
  assign bus.busy      = rstn && (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      r     <= '0;
      s     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            state <= RUN;
            r     <= RND_W'(1);
            s     <= '0;
          end
        end
        RUN: begin
          if (stage_end) begin
            s <= '0;
            if (last_round) begin
              state <= DONE;
              r     <= '0;
            end else begin
              r <= r + 1'b1;
            end
          end else begin
            s <= s + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          r     <= '0;
          s     <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NR, default 10, meaning number of AES rounds (AES-128).
REQ-002 Parameter STAGES, default 4, meaning register stages per full round in the core loop (SubBytes, ShiftRows, MixColumns, AddRoundKey).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  source offers a plaintext/key pair; the pair is presented directly to the core.
REQ-006 in_ready  output  1  controller can accept a new block.
REQ-007 accept  output  1  core load strobe for plaintext and cipher key.
REQ-008 rndNo  output  4  current round number to the core (key-schedule rcon select; final-round MixColumns bypass at value NR).
REQ-009 enbKS  output  1  core round-key register update enable.
REQ-010 out_valid  output  1  single-cycle pulse: core cipher_text is valid this cycle.
REQ-011 busy  output  1  block in flight (state not IDLE).

Function
REQ-012 States SHALL be IDLE, RUN and DONE; counters are round r (1..NR) and stage s (0..STAGES-1).
REQ-013 IDLE: in_ready=1, rndNo=0, enbKS=0, out_valid=0, busy=0.
REQ-014 accept SHALL equal in_valid AND in_ready, combinationally; the transfer cycle is T.
REQ-015 On accept: go to RUN with r=1, s=0 at the edge ending cycle T.
REQ-016 RUN: in_ready=0, busy=1, rndNo=r; in_valid is ignored.
REQ-017 For r<NR: s increments each cycle; at s=STAGES-1, enbKS=1, then r increments and s returns to 0.
REQ-018 For r=NR the round is STAGES-1 cycles (MixColumns bypassed): at s=STAGES-2, enbKS=1, then go to DONE.
REQ-019 enbKS SHALL be 1 in exactly NR cycles per block, each with rndNo equal to the round whose key is produced.
REQ-020 With defaults, RUN lasts 39 cycles (T+1..T+39).
REQ-021 DONE lasts exactly one cycle (T+40): out_valid=1, rndNo=0, enbKS=0, busy=1, in_ready=0; next state is IDLE.
REQ-022 out_valid has no backpressure; the sink captures cipher_text in the pulse cycle, since the core overwrites it on the next edge.
REQ-023 The earliest next accept is cycle T+41; maximum throughput is one block per 41 cycles.
REQ-024 in_valid held high continuously SHALL yield back-to-back blocks at the 41-cycle period, with no lost or duplicated accept.
REQ-025 rndNo SHALL never exceed NR, and r/s SHALL never wrap.

Reset
REQ-026 With rstn=0 at a rising edge: state=IDLE, r=0, s=0. Reset values: in_ready=1 after release; accept=0, rndNo=0, enbKS=0, out_valid=0 and busy=0 while rstn=0.
REQ-027 in_ready and accept SHALL be forced to 0 while rstn=0.
REQ-028 Reset mid-block SHALL abandon the block: no out_valid, and the next accept starts a clean round 1.

Structure
REQ-029 Shared package aes_pkg: NR, STAGES, the state enum (IDLE/RUN/DONE) and round-counter width; the core and controller both reference it.
REQ-030 No sub-module: a single FSM with two counters; output decode is combinational from state, r, s and in_valid.

Verification
REQ-031 Pair with the core. pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, accept at T -> out_valid only at T+40, cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-032 pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> cipher_text 3925841d02dc09fbdc118597196a0b32 at T+40; enbKS high in exactly 10 cycles, rndNo 1..10 ascending.
REQ-033 in_valid held high for 3 blocks -> accepts at T, T+41, T+82; three out_valid pulses, each with the correct ciphertext.
REQ-034 in_valid toggled during RUN -> no accept, in_ready stays 0, result unchanged.
REQ-035 rstn=0 for one edge at T+20 -> no out_valid; a new block accepted after release produces the correct ciphertext 40 cycles later.
REQ-036 Assertions: accept implies IDLE; out_valid width is exactly 1 cycle; rndNo<=10; enbKS implies RUN.
